// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, FIFO depth and output-buffer state encoding
package fifo_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int FIFO_DEPTH     = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry in-order output buffer, oldest entry always in slot0
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        occupancy
);

  buf_state_t        state;
  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;
  logic              pop_eff;

  assign pop_eff   = pop && (state != EMPTY);
  assign data_out  = slot0;
  assign occupancy = state;

  // Occupancy FSM; slot0 is the head, so data_out never needs a mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            slot0 <= data_in;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop_eff})
            2'b10: begin
              slot1 <= data_in;
              state <= TWO;
            end
            2'b01: state <= EMPTY;
            2'b11: slot0 <= data_in;
            default: ;
          endcase
        end
        TWO: begin
          // push without pop cannot happen here: the reader never over-requests.
          if (pop_eff) begin
            slot0 <= slot1;
            if (push) slot1 <= data_in;
            else      state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered read data and write-over-read priority
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              wr_ok;
  logic              rd_ok;

  // A write that lands blocks a read in the same cycle.
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty && !wr_ok;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // Storage, pointers and occupancy; read data is registered on an accepted pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + AW'(1);
        count     <= count + (AW+1)'(1);
      end
      if (rd_ok) begin
        dout  <= mem[rptr];
        rptr  <= rptr + AW'(1);
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops a synchronous FIFO and presents its bytes as a valid/ready stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              fifo_wr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       pop_cnt
);

  logic       pop_ok;
  logic       inflight;
  logic       handshake;
  logic [1:0] occupancy;
  logic [2:0] demand;

  assign handshake = m_valid && m_ready;
  // Slots that will be taken next cycle if nothing new is popped now.
  assign demand    = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, handshake};
  assign fifo_rd   = !rst && en && !fifo_empty && (demand < 3'd2);
  // A concurrent successful write wins inside the FIFO, so the pop is lost.
  assign pop_ok    = fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full);
  assign m_valid   = !rst && (buf_state_t'(occupancy) != EMPTY);

  // One pop in flight: FIFO read data becomes valid the cycle after pop_ok.
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= pop_ok;
  end

  // Count delivered bytes; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)            pop_cnt <= '0;
    else if (handshake) pop_cnt <= pop_cnt + 16'd1;
  end

  skid_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .data_in   (fifo_dout),
    .pop       (handshake),
    .data_out  (m_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - bench for fifo_stream_reader driven by a real synchronous FIFO
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_wr;
  logic [7:0]  wr_data;
  logic        fifo_rd;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] pop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bytes accepted by the FIFO must leave the stream in order, once each.
  logic [7:0] exp_q[$];
  int         model_cnt = 0;
  logic       stall = 1'b0;
  logic [7:0] held = 8'h00;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (fifo_wr),
    .wr_data (wr_data),
    .rd      (fifo_rd),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  fifo_stream_reader #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .pop_cnt    (pop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    fifo_wr = 1'b1;
    wr_data = b;
    step();
    fifo_wr = 1'b0;
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_fifo_rd", fifo_rd, 1'b0);
      exp_q.delete();
      model_cnt = 0;
      stall = 1'b0;
    end else begin
      check("pop_cnt", pop_cnt, model_cnt);
      if (stall) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, held);
      end
      check("no_overfill",
            (dut.u_buf.state == TWO) && dut.inflight && !(m_valid && m_ready), 1'b0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_output: got 0x%0h expected no byte at %0t", m_data, $time);
        end else begin
          check("stream_data", m_data, exp_q.pop_front());
        end
        model_cnt = (model_cnt + 1) % 65536;
      end
      stall = m_valid && !m_ready;
      held  = m_data;
      if (fifo_wr && !fifo_full) exp_q.push_back(wr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hs;
    rst = 1'b1; en = 1'b0; fifo_wr = 1'b0; wr_data = 8'h00; m_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_pop_cnt", pop_cnt, 16'd0);
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_empty", fifo_empty, 1'b1);
    step();

    // Full FIFO drained at one byte per cycle.
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    check("t1_full", fifo_full, 1'b1);
    en = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!m_valid && lat < 8) begin
      lat++;
      @(negedge clk);
    end
    check("t1_latency", lat, 2);
    for (int i = 0; i < 16; i++) begin
      check("t1_valid", m_valid, 1'b1);
      check("t1_data", m_data, 8'(i + 1));
      if (i < 15) @(negedge clk);
    end
    step();
    check("t1_pop_cnt", pop_cnt, 16'd16);
    check("t1_empty", fifo_empty, 1'b1);
    check("t1_idle", m_valid, 1'b0);
    en = 1'b0;

    // Back-pressure: two bytes captured, third waits in the FIFO.
    m_ready = 1'b0;
    write_byte(8'hA5); write_byte(8'h5A); write_byte(8'hC3);
    en = 1'b1;
    repeat (6) step();
    check("t2_valid", m_valid, 1'b1);
    check("t2_hold", m_data, 8'hA5);
    check("t2_rd_stop", fifo_rd, 1'b0);
    check("t2_fifo_left", fifo_empty, 1'b0);
    m_ready = 1'b1;
    @(negedge clk); check("t2_b0", m_data, 8'hA5);
    @(negedge clk); check("t2_b1", m_data, 8'h5A);
    @(negedge clk); check("t2_b2", m_data, 8'hC3);
    step(); step();
    en = 1'b0;
    check("t2_idle", m_valid, 1'b0);

    // Writer conflict: the pop in the write cycle is rejected.
    write_byte(8'h33);
    step();
    en = 1'b1; fifo_wr = 1'b1; wr_data = 8'h44;
    @(negedge clk);
    check("t3_rd_req", fifo_rd, 1'b1);
    check("t3_v0", m_valid, 1'b0);
    @(posedge clk); #1;
    fifo_wr = 1'b0;
    @(negedge clk); check("t3_v1", m_valid, 1'b0);
    @(negedge clk); check("t3_v2", m_valid, 1'b0);
    @(negedge clk); check("t3_v3", m_valid, 1'b1); check("t3_d33", m_data, 8'h33);
    @(negedge clk); check("t3_d44", m_data, 8'h44);
    @(negedge clk); check("t3_idle", m_valid, 1'b0);
    step();
    en = 1'b0;

    // en pause mid-stream: only buffered plus in-flight bytes keep flowing.
    for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i));
    en = 1'b1;
    repeat (8) step();
    en = 1'b0;
    hs = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 3 && m_valid && m_ready) hs++;
      if (k >= 2 && k <= 4) check("t4_paused", m_valid, 1'b0);
      if (k == 5) check("t4_resumed", m_valid, 1'b1);
      if (k == 2) begin
        @(posedge clk); #1;
        en = 1'b1;
      end
    end
    check("t4_after_en_fall", hs, 2);
    lat = 0;
    while ((exp_q.size() != 0 || m_valid) && lat < 40) begin
      step();
      lat++;
    end
    check("t4_drained", exp_q.size(), 0);
    en = 1'b0;

    // Reset with a byte in flight: it must be dropped.
    write_byte(8'h77); write_byte(8'h78);
    en = 1'b1;
    @(negedge clk);
    check("t5_pop", fifo_rd, 1'b1);
    @(posedge clk); #1;
    en = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_pop_cnt", pop_cnt, 16'd0);
    check("t5_valid", m_valid, 1'b0);
    check("t5_empty", fifo_empty, 1'b1);
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_no_77", m_valid, 1'b0);
    end
    step();
    en = 1'b0;
    check("final_model_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_W, default 8, data width of the FIFO read port and output stream.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  1 = reader may issue new FIFO pops; 0 = stop issuing, keep draining buffered data.
REQ-005 fifo_rd  output  1  pop request to the synchronous FIFO.
REQ-006 fifo_dout  input  DATA_W  FIFO registered read data, valid the cycle after an accepted pop.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_full  input  1  FIFO full flag.
REQ-009 fifo_wr  input  1  copy of the writer's write request (observed only, used for write-priority detection).
REQ-010 m_data  output  DATA_W  output stream data.
REQ-011 m_valid  output  1  output stream valid.
REQ-012 m_ready  input  1  output stream ready from consumer.
REQ-013 pop_cnt  output  16  count of bytes delivered on the output stream, wraps at 65535 -> 0.

Function
REQ-014 Pop accepted (internal pop_ok) SHALL equal fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full), matching FIFO write-over-read priority.
REQ-015 A rejected pop (fifo_rd high, pop_ok low) SHALL NOT create an in-flight entry; the request is simply re-evaluated next cycle.
REQ-016 inflight SHALL be a 1-bit register set to pop_ok each cycle; when inflight=1, fifo_dout SHALL be captured into the output buffer that cycle.
REQ-017 Output buffer SHALL hold 2 entries, FIFO order, tracked by FSM states EMPTY(0), ONE(1), TWO(2).
REQ-018 Transitions: +1 on capture without output handshake, -1 on handshake (m_valid && m_ready) without capture, unchanged when both or neither occur.
REQ-019 fifo_rd SHALL be asserted combinationally iff en && !fifo_empty && (occupancy + inflight - (m_valid && m_ready)) < 2.
REQ-020 m_valid SHALL be 1 iff state != EMPTY; m_data SHALL be the oldest entry; m_data SHALL be held stable while m_valid && !m_ready.
REQ-021 Capture into EMPTY SHALL make data visible on m_data/m_valid the cycle after capture; total latency pop_ok -> m_valid = 2 cycles.
REQ-022 Sustained throughput SHALL be 1 byte/cycle when FIFO non-empty, no writer conflict, en=1, m_ready=1.
REQ-023 Capture while in TWO without a handshake SHALL never occur; REQ-019 guarantees this (assertion in verification).
REQ-024 en deassertion SHALL take effect the same cycle for fifo_rd; an already in-flight byte SHALL still be captured and delivered.
REQ-025 pop_cnt SHALL increment by 1 on each output handshake.

Reset
REQ-026 On rst=1 at posedge clk: state=EMPTY, inflight=0, pop_cnt=0, buffer contents don't-care.
REQ-027 During rst=1: fifo_rd=0 and m_valid=0; an in-flight byte at reset SHALL be discarded.
REQ-028 The first pop MAY be issued in the first cycle with rst=0.

Structure
REQ-029 Shared package fifo_pkg SHALL hold DATA_W default (8), FIFO_DEPTH (16) and the buffer state encoding (EMPTY/ONE/TWO).
REQ-030 The 2-entry buffer SHALL be a sub-module skid_buf2 (push, data_in, pop, data_out, occupancy); fifo_stream_reader keeps pop_ok, inflight, fifo_rd logic and pop_cnt.

Verification
REQ-031 Bench SHALL instantiate the synchronous FIFO, with the same clk/rst, driving this block.
REQ-032 Write 0x01..0x10 (16 bytes, FIFO full), en=1, m_ready=1 -> m_data 0x01..0x10 on 16 consecutive cycles, pop_cnt=16, fifo_empty=1 at end.
REQ-033 FIFO holds 0xA5, 0x5A, m_ready=0 -> m_valid=1, m_data=0xA5 held, fifo_rd drops after 2 captured; m_ready=1 -> 0xA5 then 0x5A, no duplicates or losses.
REQ-034 FIFO holds 0x33, fifo_wr=1 with fifo_full=0 in the same cycle as fifo_rd -> pop rejected, no capture; next cycle without write -> 0x33 delivered once.
REQ-035 Stream of 0x10..0x1F, en=0 for 3 cycles mid-stream -> at most 1 in-flight byte delivered after en falls, order preserved, resumes on en=1.
REQ-036 rst asserted one cycle after a pop_ok of 0x77 -> m_valid=0, pop_cnt=0 after reset, 0x77 never appears on m_data.
